// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - CPU/DMA arbiter for the shared data-memory port
//
// Purpose:
//   Owns the single data-memory port. The CPU holds the bus by default; the
//   DMA engine asks for it with BR and owns it while BG is high. A CPU access
//   presented in the same cycle that BR is first honoured is serviced first
//   (one DRAIN cycle). Every release costs one turnaround cycle, and after it
//   the CPU keeps the bus for MIN_CPU_GAP cycles before BR is honoured again.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   cpu_d_readM/writeM/address/wdata CPU data-side request
//   cpu_stall                       CPU must hold its request
//   BR / BG                         DMA bus request / grant
//   dma_WRITE/addr/offset/data      DMA write stream
//   mem_readM/writeM/address/wdata  muxed request toward memory
//   dma_grants, dma_cycles          statistics counters
//
// Configuration:
//   DMA_ARB_STATS_EN  when defined, dma_grants/dma_cycles count grants and
//                     granted cycles (saturating); otherwise both read zero.

module dma_bus_arbiter #(
   parameter int WORD_SIZE   = 16,
   parameter int LINE_SIZE   = 64,
   parameter int MIN_CPU_GAP = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cpu_d_readM,
   input  logic                 cpu_d_writeM,
   input  logic [WORD_SIZE-1:0] cpu_d_address,
   input  logic [LINE_SIZE-1:0] cpu_d_wdata,
   output logic                 cpu_stall,
   input  logic                 BR,
   output logic                 BG,
   input  logic                 dma_WRITE,
   input  logic [WORD_SIZE-1:0] dma_addr,
   input  logic [1:0]           dma_offset,
   input  logic [LINE_SIZE-1:0] dma_data,
   output logic                 mem_readM,
   output logic                 mem_writeM,
   output logic [WORD_SIZE-1:0] mem_address,
   output logic [LINE_SIZE-1:0] mem_wdata,
   output logic [15:0]          dma_grants,
   output logic [15:0]          dma_cycles
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DRAIN   = 2'd1,
      S_GRANTED = 2'd2,
      S_RELEASE = 2'd3
   } state_e;

   // Keep the gap counter at least one bit wide so MIN_CPU_GAP=0 still builds;
   // it then stays at zero forever.
   localparam int GAP_W = (MIN_CPU_GAP > 0) ? $clog2(MIN_CPU_GAP + 1) : 1;

   state_e             state_q, state_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               gap_done;
   logic               cpu_req;

   assign gap_done = (gap_q == '0);
   assign cpu_req  = cpu_d_readM | cpu_d_writeM;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (!gap_done) begin
               gap_d = gap_q - GAP_W'(1);
            end
            // A CPU access in this cycle completes now; the DMA follows
            // after a single DRAIN cycle.
            if (BR && gap_done) begin
               state_d = cpu_req ? S_DRAIN : S_GRANTED;
            end
         end
         S_DRAIN: begin
            state_d = BR ? S_GRANTED : S_IDLE;
         end
         S_GRANTED: begin
            if (!BR) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
            gap_d   = GAP_W'(MIN_CPU_GAP);
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign BG        = (state_q == S_GRANTED);
   assign cpu_stall = (state_q != S_IDLE) && cpu_req;

   // DRAIN and RELEASE drive nothing so neither master sees a half-owned bus.
   always_comb begin
      mem_readM   = 1'b0;
      mem_writeM  = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      case (state_q)
         S_IDLE: begin
            mem_readM   = cpu_d_readM;
            mem_writeM  = cpu_d_writeM;
            mem_address = cpu_d_address;
            mem_wdata   = cpu_d_wdata;
         end
         S_GRANTED: begin
            mem_writeM  = dma_WRITE;
            mem_address = dma_addr + WORD_SIZE'(dma_offset);
            mem_wdata   = dma_data;
         end
         default: begin
         end
      endcase
   end

`ifdef DMA_ARB_STATS_EN
   logic [15:0] grants_q, grants_d;
   logic [15:0] cycles_q, cycles_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         grants_q <= '0;
         cycles_q <= '0;
      end else begin
         grants_q <= grants_d;
         cycles_q <= cycles_d;
      end
   end

   always_comb begin
      grants_d = grants_q;
      cycles_d = cycles_q;
      if ((state_d == S_GRANTED) && (state_q != S_GRANTED) && (grants_q != 16'hFFFF)) begin
         grants_d = grants_q + 16'd1;
      end
      if ((state_q == S_GRANTED) && (cycles_q != 16'hFFFF)) begin
         cycles_d = cycles_q + 16'd1;
      end
   end

   assign dma_grants = grants_q;
   assign dma_cycles = cycles_q;
`else
   assign dma_grants = 16'h0000;
   assign dma_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - randomized self-checking bench for dma_bus_arbiter

module tb_dma_bus_arbiter;

   localparam int WS  = 16;
   localparam int LS  = 64;
   localparam int GAP = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cpu_d_readM, cpu_d_writeM;
   logic [WS-1:0] cpu_d_address;
   logic [LS-1:0] cpu_d_wdata;
   logic          cpu_stall;
   logic          BR, BG;
   logic          dma_WRITE;
   logic [WS-1:0] dma_addr;
   logic [1:0]    dma_offset;
   logic [LS-1:0] dma_data;
   logic          mem_readM, mem_writeM;
   logic [WS-1:0] mem_address;
   logic [LS-1:0] mem_wdata;
   logic [15:0]   dma_grants, dma_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: who owns the bus, expressed as independent flags.
   bit m_dma, m_drain, m_turn;
   int m_gap, m_grants, m_cycles;

   dma_bus_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS), .MIN_CPU_GAP(GAP)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_d_readM(cpu_d_readM), .cpu_d_writeM(cpu_d_writeM),
      .cpu_d_address(cpu_d_address), .cpu_d_wdata(cpu_d_wdata),
      .cpu_stall(cpu_stall), .BR(BR), .BG(BG),
      .dma_WRITE(dma_WRITE), .dma_addr(dma_addr), .dma_offset(dma_offset),
      .dma_data(dma_data),
      .mem_readM(mem_readM), .mem_writeM(mem_writeM),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .dma_grants(dma_grants), .dma_cycles(dma_cycles)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input bit br, input bit rd, input bit wr, input logic [WS-1:0] caddr,
                         input bit dw, input logic [WS-1:0] daddr, input logic [1:0] off);
      BR            = br;
      cpu_d_readM   = rd;
      cpu_d_writeM  = wr;
      cpu_d_address = caddr;
      cpu_d_wdata   = {$urandom, $urandom};
      dma_WRITE     = dw;
      dma_addr      = daddr;
      dma_offset    = off;
      dma_data      = {$urandom, $urandom};
   endtask

   // Compare every output against the model for the inputs now applied.
   task automatic compare_all();
      bit            busy;
      logic          e_rd, e_wr;
      logic [WS-1:0] e_addr;
      logic [LS-1:0] e_data;
      #1;
      busy = m_dma || m_drain || m_turn;
      if (m_dma) begin
         e_rd = 1'b0; e_wr = dma_WRITE;
         e_addr = WS'((int'(dma_addr) + int'(dma_offset)) % 65536);
         e_data = dma_data;
      end else if (busy) begin
         e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
      end else begin
         e_rd = cpu_d_readM; e_wr = cpu_d_writeM;
         e_addr = cpu_d_address; e_data = cpu_d_wdata;
      end
      check_val("bg", BG, m_dma);
      check_val("stall", cpu_stall, busy && (cpu_d_readM || cpu_d_writeM));
      check_val("mem_readM", mem_readM, e_rd);
      check_val("mem_writeM", mem_writeM, e_wr);
      check_val("mem_address", mem_address, e_addr);
      check_val("mem_wdata", mem_wdata, e_data);
`ifdef DMA_ARB_STATS_EN
      check_val("dma_grants", dma_grants, m_grants);
      check_val("dma_cycles", dma_cycles, m_cycles);
`else
      check_val("dma_grants", dma_grants, 0);
      check_val("dma_cycles", dma_cycles, 0);
`endif
   endtask

   // Advance one clock and apply the ownership rules to the model.
   task automatic tick();
      bit n_dma, n_drain, n_turn;
      int n_gap;
      @(posedge clk);
      if (!reset_n) begin
         m_dma = 0; m_drain = 0; m_turn = 0; m_gap = 0; m_grants = 0; m_cycles = 0;
      end else begin
         n_dma = 0; n_drain = 0; n_turn = 0; n_gap = m_gap;
         if (m_dma) begin
            if (BR) n_dma = 1; else n_turn = 1;
         end else if (m_drain) begin
            if (BR) n_dma = 1;
         end else if (m_turn) begin
            n_gap = GAP;
         end else begin
            if (m_gap > 0) n_gap = m_gap - 1;
            if (BR && m_gap == 0) begin
               if (cpu_d_readM || cpu_d_writeM) n_drain = 1; else n_dma = 1;
            end
         end
         if (n_dma && !m_dma && m_grants < 65535) m_grants++;
         if (m_dma && m_cycles < 65535) m_cycles++;
         m_dma = n_dma; m_drain = n_drain; m_turn = n_turn; m_gap = n_gap;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      set_in(0, 0, 0, '0, 0, '0, 2'd0);
      compare_all();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      int waited;
      reset_n = 1'b0;
      set_in(0, 0, 0, '0, 0, '0, 2'd0);
      m_dma = 0; m_drain = 0; m_turn = 0; m_gap = 0; m_grants = 0; m_cycles = 0;
      @(negedge clk);
      tick();
      reset_n = 1'b1;

      // Reset state: CPU pass-through, no grant, no stall.
      set_in(0, 1, 0, 16'h0ABC, 0, '0, 2'd0);
      compare_all();
      check_val("rst_bg", BG, 0);
      check_val("rst_pass", mem_address, 16'h0ABC);
      check_val("rst_stall", cpu_stall, 0);
      tick();

      // Idle grant and DMA write with offset.
      set_in(1, 0, 0, '0, 0, '0, 2'd0);
      compare_all();
      check_val("idle_bg_early", BG, 0);
      tick();
      set_in(1, 0, 0, '0, 1, 16'h01F0, 2'd3);
      compare_all();
      check_val("idle_bg", BG, 1);
      check_val("dma_wr", mem_writeM, 1);
      check_val("dma_addr", mem_address, 16'h01F3);

      // Hold for 12 granted cycles, drop, then re-request against the gap.
      for (int i = 0; i < 11; i++) begin
         tick();
         set_in(1, $urandom_range(0, 1), 0, 16'h2222, $urandom_range(0, 1), 16'hFFFE, 2'($urandom));
         compare_all();
      end
      tick();
      set_in(0, 0, 1, 16'h3333, 0, '0, 2'd0);
      compare_all();
      tick();
      set_in(1, 1, 0, 16'h3333, 0, '0, 2'd0);
      compare_all();
      check_val("release_bg", BG, 0);
      check_val("release_addr", mem_address, 0);
      check_val("release_stall", cpu_stall, 1);
      waited = 0;
      while (BG !== 1'b1 && waited < 20) begin
         tick();
         waited++;
         set_in(1, 0, 0, '0, 0, '0, 2'd0);
         compare_all();
      end
      check_val("gap_wait", waited, 6);

      // CPU read in flight when BR rises: one DRAIN cycle first.
      do_reset();
      set_in(1, 1, 0, 16'h1234, 0, '0, 2'd0);
      compare_all();
      check_val("drain_cpu_rd", mem_readM, 1);
      check_val("drain_cpu_addr", mem_address, 16'h1234);
      tick();
      set_in(1, 1, 0, 16'h1238, 0, '0, 2'd0);
      compare_all();
      check_val("drain_bg", BG, 0);
      check_val("drain_stall", cpu_stall, 1);
      check_val("drain_rd0", mem_readM, 0);
      tick();
      set_in(1, 0, 1, 16'h1238, 0, 16'h0010, 2'd1);
      compare_all();
      check_val("drain_then_bg", BG, 1);
      check_val("granted_stall", cpu_stall, 1);

      // BR withdrawn during DRAIN.
      do_reset();
      set_in(1, 0, 1, 16'h4444, 0, '0, 2'd0);
      compare_all();
      tick();
      set_in(0, 1, 0, 16'h4444, 0, '0, 2'd0);
      compare_all();
      tick();
      set_in(0, 1, 0, 16'h4448, 0, '0, 2'd0);
      compare_all();
      check_val("withdraw_bg", BG, 0);
      check_val("withdraw_stall", cpu_stall, 0);

      // Reset while granted.
      tick();
      set_in(1, 0, 0, '0, 0, '0, 2'd0);
      compare_all();
      tick(); tick();
      set_in(1, 0, 0, '0, 0, '0, 2'd0);
      compare_all();
      check_val("pre_rst_bg", BG, 1);
      do_reset();
      set_in(1, 0, 0, '0, 0, '0, 2'd0);
      compare_all();
      check_val("midrst_bg", BG, 0);
      check_val("midrst_grants", dma_grants, 0);

      // Three grants of four cycles each.
      do_reset();
      for (int g = 0; g < 3; g++) begin
         for (int c = 0; c < 4; c++) begin
            set_in(1, 0, 0, '0, 1, 16'($urandom), 2'($urandom));
            compare_all();
            tick();
         end
         for (int c = 0; c < 7; c++) begin
            set_in(0, $urandom_range(0, 1), 0, 16'($urandom), 0, '0, 2'd0);
            compare_all();
            tick();
         end
      end
      set_in(0, 0, 0, '0, 0, '0, 2'd0);
      compare_all();
`ifdef DMA_ARB_STATS_EN
      check_val("stat_grants", dma_grants, 3);
      check_val("stat_cycles", dma_cycles, 12);
`else
      check_val("stat_grants", dma_grants, 0);
      check_val("stat_cycles", dma_cycles, 0);
`endif

      // Randomized traffic with sticky BR and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bit br_n;
         br_n = ($urandom_range(0, 7) == 0) ? !BR : BR;
         reset_n = ($urandom_range(0, 299) != 0);
         set_in(br_n, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 16'($urandom),
                $urandom_range(0, 1), 16'($urandom), 2'($urandom));
         compare_all();
         tick();
      end
      reset_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
